// File: rtl/alu_host_driver.sv
// alu_host_driver: serialises a 32-bit A/B request into byte transfers to a byte-wide ALU and collects the 4-byte result.
// Optional WAIT_DONE watchdog enabled by defining ALU_DRV_TIMEOUT_EN.
module alu_host_driver #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_opcode,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result,
   output logic        rsp_err,
   output logic        alu_start,
   output logic [7:0]  alu_in,
   output logic [1:0]  alu_opcode,
   input  logic [7:0]  alu_out,
   input  logic        alu_done,
   input  logic [3:0]  alu_state
);
   typedef enum logic [2:0] {IDLE, START, SEND, WAIT_DONE, RECV, RESP} state_t;
   state_t      state;
   logic [2:0]  cnt;
   logic [63:0] ops;
   logic [31:0] result;
   logic [1:0]  op;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   // reset gates req_ready directly so it drops the moment rst rises
   assign req_ready  = (state == IDLE) && !rst;
   assign rsp_valid  = state == RESP;
   assign rsp_result = result;
   assign alu_opcode = op;
   assign alu_start  = (state == START) && (alu_state == 4'd0);
   assign alu_in     = (state == SEND) ? ops[{cnt, 3'b000} +: 8] : 8'd0;

`ifdef ALU_DRV_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
   logic [WW-1:0] wd;
   logic          err;
   assign rsp_err = err;
`else
   assign rsp_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         ops    <= '0;
         result <= '0;
         op     <= '0;
`ifdef ALU_DRV_TIMEOUT_EN
         wd     <= '0;
         err    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               ops   <= {req_b, req_a};
               op    <= req_opcode;
               state <= START;
`ifdef ALU_DRV_TIMEOUT_EN
               err   <= 1'b0;
`endif
            end
            START: if (alu_state == 4'd0) begin
               cnt   <= '0;
               state <= SEND;
            end
            SEND: begin
               cnt <= cnt + 3'd1;
               if (cnt == 3'd7) state <= WAIT_DONE;
            end
            WAIT_DONE: if (alu_done) begin
               result[7:0] <= alu_out;
               cnt         <= '0;
               state       <= RECV;
`ifdef ALU_DRV_TIMEOUT_EN
               wd          <= '0;
            end else if (wd == WW'(TIMEOUT_CYCLES - 1)) begin
               wd     <= '0;
               result <= '0;
               err    <= 1'b1;
               state  <= RESP;
            end else begin
               wd <= wd + WW'(1);
`endif
            end
            RECV: begin
               result[{cnt[1:0] + 2'd1, 3'b000} +: 8] <= alu_out;
               cnt <= (cnt == 3'd2) ? 3'd0 : cnt + 3'd1;
               if (cnt == 3'd2) state <= RESP;
            end
            RESP: if (rsp_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_host_driver.sv
// tb_alu_host_driver: directed checks of alu_host_driver against a cycle-exact byte-ALU model.
// Watchdog checks follow ALU_DRV_TIMEOUT_EN.
module tb_alu_host_driver;
   logic        clk = 1'b0;
   logic        rst, req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, alu_start, alu_done;
   logic [1:0]  req_opcode, alu_opcode;
   logic [31:0] req_a, req_b, rsp_result;
   logic [7:0]  alu_in, alu_out;
   logic [3:0]  alu_state;
   int          n_chk = 0, n_fail = 0;

   int          cyc = 0, mcnt = 0, busy_end, n;
   logic        never_done, seen;
   logic [31:0] model_res;
   logic [63:0] cap = '0;

   alu_host_driver #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_err(rsp_err),
      .alu_start(alu_start), .alu_in(alu_in), .alu_opcode(alu_opcode),
      .alu_out(alu_out), .alu_done(alu_done), .alu_state(alu_state)
   );

   always #5 clk = ~clk;

   // ALU model: bytes in 1..8 cycles after start, done + result bytes 11..14, spurious done at 5
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mcnt != 0) mcnt <= (mcnt == 14) ? 0 : mcnt + 1;
      else if (alu_start) mcnt <= 1;
      if (mcnt >= 1 && mcnt <= 8) cap[8*(mcnt-1) +: 8] <= alu_in;
   end
   assign alu_state = (cyc < busy_end) ? 4'd5 : (mcnt != 0 ? 4'd3 : 4'd0);
   assign alu_done  = (mcnt == 5) || (mcnt >= 11 && !never_done);
   assign alu_out   = (mcnt >= 11 && mcnt <= 14) ? model_res[8*(mcnt-11) +: 8] : 8'hA5;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_req(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
      req_a = a; req_b = b; req_opcode = op; req_valid = 1'b1;
      chk("req_ready_idle", req_ready, 1);
      step();
      req_valid = 1'b0; req_a = '0; req_b = '0; req_opcode = 2'd0;
   endtask

   task automatic wait_rsp(input int lim, output int cnt);
      cnt = 0;
      while (!rsp_valid && cnt < lim) begin
         step();
         cnt++;
      end
      chk("rsp_arrived", rsp_valid, 1);
   endtask

   task automatic run_std(input string t, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op, input logic [31:0] res);
      logic [63:0] ab;
      ab = {b, a};
      model_res = res;
      do_req(a, b, op);
      chk({t, "_start"}, alu_start, 1);
      chk({t, "_op_t1"}, alu_opcode, op);
      chk({t, "_in_start"}, alu_in, 0);
      for (int i = 0; i < 8; i++) begin
         step();
         chk({t, "_byte"}, alu_in, ab[8*i +: 8]);
         chk({t, "_start_once"}, alu_start, 0);
      end
      chk({t, "_op_t9"}, alu_opcode, op);
      step();
      chk({t, "_in_wait"}, alu_in, 0);
      repeat (5) step();
      chk({t, "_no_rsp_t15"}, rsp_valid, 0);
      step();
      chk({t, "_rsp_t16"}, rsp_valid, 1);
      chk({t, "_result"}, rsp_result, res);
      chk({t, "_err"}, rsp_err, 0);
      chk({t, "_busy_ready"}, req_ready, 0);
      chk({t, "_operands"}, cap, ab);
      chk({t, "_op_t16"}, alu_opcode, op);
      step();
      chk({t, "_ready_after"}, req_ready, 1);
      chk({t, "_rsp_drop"}, rsp_valid, 0);
      chk({t, "_op_held"}, alu_opcode, op);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_opcode = '0; rsp_ready = 1'b1;
      never_done = 1'b0; busy_end = 0; model_res = '0;
      step(); step();
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_result", rsp_result, 0);
      chk("rst_err", rsp_err, 0);
      chk("rst_start", alu_start, 0);
      chk("rst_in", alu_in, 0);
      chk("rst_opcode", alu_opcode, 0);
      rst = 1'b0;
      #1;
      chk("ready_after_rst", req_ready, 1);

      run_std("add", 32'h3F800000, 32'h40000000, 2'b00, 32'h40400000);
      run_std("sub", 32'h40400000, 32'h3F800000, 2'b01, 32'h40000000);

      // busy ALU for the three cycles after acceptance
      model_res = 32'h40A00000;
      busy_end = cyc + 4;
      do_req(32'h40000000, 32'h40400000, 2'b00);
      chk("busy_t1", alu_start, 0);
      step(); chk("busy_t2", alu_start, 0);
      step(); chk("busy_t3", alu_start, 0);
      step(); chk("busy_t4_start", alu_start, 1);
      step(); chk("busy_byte0", alu_in, 8'h00);
      wait_rsp(30, n);
      chk("busy_rsp_cycle", n, 14);
      chk("busy_result", rsp_result, 32'h40A00000);
      step();

      // backpressure
      rsp_ready = 1'b0;
      model_res = 32'hBF800000;
      do_req(32'h3F800000, 32'h40000000, 2'b01);
      wait_rsp(30, n);
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", rsp_valid, 1);
         chk("bp_result", rsp_result, 32'hBF800000);
         chk("bp_ready", req_ready, 0);
         step();
      end
      rsp_ready = 1'b1;
      chk("bp_still_valid", rsp_valid, 1);
      step();
      chk("bp_idle_ready", req_ready, 1);
      chk("bp_released", rsp_valid, 0);

      // reset at the 4th SEND byte, ALU model keeps running
      model_res = 32'h40000000;
      do_req(32'h40400000, 32'h3F800000, 2'b01);
      repeat (4) step();
      chk("rs_byte3", alu_in, 8'h40);
      #2 rst = 1'b1;
      #1;
      chk("rs_in", alu_in, 0);
      chk("rs_ready", req_ready, 0);
      chk("rs_opcode", alu_opcode, 0);
      chk("rs_result", rsp_result, 0);
      chk("rs_valid", rsp_valid, 0);
      chk("rs_start", alu_start, 0);
      step(); step();
      rst = 1'b0;
      #1;
      chk("rs_ready_after", req_ready, 1);
      chk("rs_no_rsp", rsp_valid, 0);
      do_req(32'h40400000, 32'h3F800000, 2'b01);
      chk("rs_wait_start", alu_start, 0);
      n = 0;
      while (!alu_start && n < 20) begin
         step();
         n++;
      end
      chk("rs_start_cycle", n, 8);
      wait_rsp(30, n);
      chk("rs_rsp_cycle", n, 15);
      chk("rs_result_new", rsp_result, 32'h40000000);
      chk("rs_operands", cap, 64'h3F800000_40400000);
      step();

      // ALU that never signals done
      never_done = 1'b1;
      model_res = 32'h12345678;
      do_req(32'h40000000, 32'h40000000, 2'b00);
`ifdef ALU_DRV_TIMEOUT_EN
      wait_rsp(40, n);
      chk("to_cycle", n, 25);
      chk("to_err", rsp_err, 1);
      chk("to_result", rsp_result, 0);
      step();
      never_done = 1'b0;
      model_res = 32'h40800000;
      do_req(32'h40000000, 32'h40000000, 2'b00);
      chk("to_err_clear", rsp_err, 0);
      wait_rsp(30, n);
      chk("to_next_result", rsp_result, 32'h40800000);
      step();
`else
      seen = 1'b0;
      repeat (40) begin
         step();
         if (rsp_valid) seen = 1'b1;
      end
      chk("nd_no_rsp", seen, 0);
      chk("nd_err_tied", rsp_err, 0);
      chk("nd_stuck", req_ready, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      never_done = 1'b0;
      #1;
      chk("nd_recover", req_ready, 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_host_driver.md
ALU_HOST_DRIVER -- requirements
Module: alu_host_driver

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, SHALL set the WAIT_DONE watchdog limit in cycles; used only when ALU_DRV_TIMEOUT_EN is defined.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 req_valid  input  1  SHALL indicate that a request is present.
REQ-005 req_ready  output  1  SHALL indicate the driver accepts a request this cycle.
REQ-006 req_opcode  input  2  SHALL be the operation code: 00 add, 01 sub.
REQ-007 req_a  input  32  SHALL be operand A (IEEE-754 single).
REQ-008 req_b  input  32  SHALL be operand B (IEEE-754 single).
REQ-009 rsp_valid  output  1  SHALL indicate that a response is present.
REQ-010 rsp_ready  input  1  SHALL indicate the consumer takes the response.
REQ-011 rsp_result  output  32  SHALL carry the assembled 32-bit result.
REQ-012 rsp_err  output  1  SHALL flag a timed-out transaction.
REQ-013 alu_start  output  1  SHALL be the ALU start strobe.
REQ-014 alu_in  output  8  SHALL be the operand byte bus to the ALU.
REQ-015 alu_opcode  output  2  SHALL be the opcode presented to the ALU.
REQ-016 alu_out  input  8  SHALL be the result byte bus from the ALU.
REQ-017 alu_done  input  1  SHALL be the ALU done flag.
REQ-018 alu_state  input  4  SHALL be the ALU state; 4'd0 means the ALU is IDLE.

Function
REQ-019 The FSM SHALL have the states IDLE, START, SEND, WAIT_DONE, RECV and RESP, with a 3-bit byte counter shared by SEND and RECV.
REQ-020 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted on req_valid&&req_ready, with req_a, req_b and req_opcode registered.
REQ-021 alu_opcode SHALL hold the registered opcode from acceptance until the next acceptance.
REQ-022 START: alu_start SHALL be 1 for exactly one cycle, in the first cycle with alu_state==0; while alu_state!=0 the FSM SHALL stay in START with alu_start=0.
REQ-023 SEND: for the 8 cycles immediately after the alu_start cycle, alu_in SHALL carry A[7:0], A[15:8], A[23:16], A[31:24], B[7:0], B[15:8], B[23:16], B[31:24] in that order; alu_in SHALL be 0 outside SEND.
REQ-024 WAIT_DONE: the FSM SHALL wait for alu_done=1, and the cycle where alu_done is first seen 1 SHALL capture alu_out as result[7:0].
REQ-025 RECV: the next three consecutive cycles SHALL capture alu_out into result[15:8], [23:16] and [31:24]; alu_done SHALL be ignored during RECV.
REQ-026 alu_done SHALL be ignored in every state except WAIT_DONE.
REQ-027 RESP: rsp_valid SHALL be 1 with rsp_result stable until rsp_valid&&rsp_ready, then the FSM SHALL return to IDLE in the next cycle.
REQ-028 With a compliant ALU, acceptance at cycle T SHALL give alu_start at T+1, bytes at T+2..T+9, alu_done seen at T+12, and rsp_valid at T+16.
REQ-029 rsp_valid and req_ready SHALL never be 1 in the same cycle; only one transaction SHALL be outstanding at a time.

Reset
REQ-030 While rst=1, the FSM SHALL go to IDLE immediately and req_ready=0, rsp_valid=0, rsp_result=0, rsp_err=0, alu_start=0, alu_in=0, alu_opcode=0, and all counters SHALL be 0.
REQ-031 req_ready SHALL go to 1 in the first cycle after rst deasserts.
REQ-032 A reset mid-transaction SHALL drop the transaction with no response; the next transaction SHALL wait in START until alu_state==0.

Configuration
REQ-033 With macro ALU_DRV_TIMEOUT_EN defined, a watchdog SHALL count cycles in WAIT_DONE.
REQ-034 With ALU_DRV_TIMEOUT_EN defined, after TIMEOUT_CYCLES cycles without alu_done the FSM SHALL go to RESP with rsp_err=1 and rsp_result=0; rsp_err SHALL clear on the next acceptance.
REQ-035 Without ALU_DRV_TIMEOUT_EN, no watchdog SHALL exist, rsp_err SHALL be tied to 0, and WAIT_DONE SHALL wait indefinitely.

Verification
REQ-036 Add: A=0x3F800000, B=0x40000000, opcode 00, driving the real ALU -> alu_in=00,00,80,3F,00,00,00,40 and rsp_result=0x40400000 at T+16.
REQ-037 Sub: A=0x40400000, B=0x3F800000, opcode 01 -> alu_opcode=01 held throughout and rsp_result=0x40000000.
REQ-038 Busy ALU: a model holds alu_state=4'd5 for 3 cycles after acceptance -> alu_start asserts at T+4, not before.
REQ-039 Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_result held, req_ready=0; on rsp_ready=1 -> IDLE and req_ready=1 in the next cycle.
REQ-040 Reset at the 4th SEND byte -> all outputs 0 at once; a new request then completes correctly once alu_state returns to 0.
REQ-041 With ALU_DRV_TIMEOUT_EN and TIMEOUT_CYCLES=16, a model never asserts alu_done -> rsp_valid=1, rsp_err=1, rsp_result=0 after 16 WAIT_DONE cycles.
